// File: rtl/ysyx_24070014_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch handshake, decode steering, LSU handshake, writeback pulses.
module ysyx_24070014_ctrl_fsm #(
  parameter logic [31:0] INST_RESET = 32'h00000013,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_ifu_req,
  input  logic        i_ifu_valid,
  input  logic [31:0] i_ifu_inst,
  output logic [31:0] o_inst_q,
  output logic [2:0]  o_imm_sel,
  output logic        o_alu_a_pc,
  output logic        o_alu_b_imm,
  output logic        o_lsu_req,
  output logic        o_lsu_wen,
  input  logic        i_lsu_done,
  input  logic        i_br_taken,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_halt,
  output logic        o_illegal,
  output logic        o_bus_err
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [31:0] EBREAK    = 32'h00100073;
  // Count value at which the next un-acknowledged MEM cycle saturates the watchdog
  localparam logic [TIMEOUT_W-1:0] WDOG_LIM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                r_state, w_next;
  logic [31:0]           r_inst;
  logic [2:0]            r_imm_sel;
  logic                  r_a_pc, r_b_imm, r_is_load, r_is_store, r_is_branch;
  logic [1:0]            r_wb_sel, r_pc_cls;
  logic                  r_illegal, r_bus_err;
  logic [TIMEOUT_W-1:0]  r_wdog;

  logic [2:0]            w_imm_sel;
  logic                  w_a_pc, w_b_imm, w_is_load, w_is_store, w_is_branch, w_legal, w_ebreak;
  logic [1:0]            w_wb_sel, w_pc_cls;
  logic                  w_timeout;

  assign w_ebreak  = (r_inst == EBREAK);
  assign w_timeout = (r_wdog == WDOG_LIM) && !i_lsu_done;

  // Opcode classification of the latched instruction
  always_comb begin
    w_imm_sel   = 3'd0;
    w_a_pc      = 1'b0;
    w_b_imm     = 1'b0;
    w_wb_sel    = 2'd0;
    w_pc_cls    = 2'd0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_legal     = 1'b1;
    case (r_inst[6:0])
      OP_LUI:    begin w_imm_sel = 3'd5; w_b_imm = 1'b1; end
      OP_AUIPC:  begin w_imm_sel = 3'd5; w_b_imm = 1'b1; w_a_pc = 1'b1; end
      OP_JAL:    begin w_imm_sel = 3'd4; w_b_imm = 1'b1; w_a_pc = 1'b1; w_wb_sel = 2'd2; w_pc_cls = 2'd1; end
      OP_JALR:   begin w_imm_sel = 3'd1; w_b_imm = 1'b1; w_wb_sel = 2'd2; w_pc_cls = 2'd2; end
      OP_BRANCH: begin w_imm_sel = 3'd3; w_b_imm = 1'b1; w_a_pc = 1'b1; w_is_branch = 1'b1; end
      OP_LOAD:   begin w_imm_sel = 3'd1; w_b_imm = 1'b1; w_wb_sel = 2'd1; w_is_load = 1'b1; end
      OP_STORE:  begin w_imm_sel = 3'd2; w_b_imm = 1'b1; w_is_store = 1'b1; end
      OP_IMM:    begin w_imm_sel = 3'd1; w_b_imm = 1'b1; end
      OP_OP:     begin w_imm_sel = 3'd0; end
      default:   w_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:   w_next = S_FETCH;
      S_FETCH:  if (i_ifu_valid) w_next = S_DECODE;
      S_DECODE: begin
        if (w_ebreak || !w_legal) w_next = S_HALT;
        else                      w_next = S_EXEC;
      end
      S_EXEC:   w_next = (r_is_load || r_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (i_lsu_done)     w_next = S_WB;
        else if (w_timeout) w_next = S_HALT;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_BOOT;
    endcase
  end

  // Instruction latch, decode registers, watchdog and sticky halt causes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst      <= INST_RESET;
      r_imm_sel   <= 3'd0;
      r_a_pc      <= 1'b0;
      r_b_imm     <= 1'b0;
      r_wb_sel    <= 2'd0;
      r_pc_cls    <= 2'd0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_wdog      <= '0;
    end else begin
      if (r_state == S_FETCH && i_ifu_valid) r_inst <= i_ifu_inst;
      if (r_state == S_DECODE) begin
        r_imm_sel   <= w_imm_sel;
        r_a_pc      <= w_a_pc;
        r_b_imm     <= w_b_imm;
        r_wb_sel    <= w_wb_sel;
        r_pc_cls    <= w_pc_cls;
        r_is_load   <= w_is_load;
        r_is_store  <= w_is_store;
        r_is_branch <= w_is_branch;
        if (!w_ebreak && !w_legal) r_illegal <= 1'b1;
      end
      if (r_state == S_MEM) begin
        r_wdog <= i_lsu_done ? '0 : r_wdog + TIMEOUT_W'(1);
        if (w_timeout) r_bus_err <= 1'b1;
      end
    end
  end

  // Outputs decoded from state and decode registers; requests fall with the async reset
  always_comb begin
    o_ifu_req   = (r_state == S_FETCH);
    o_lsu_req   = (r_state == S_MEM);
    o_lsu_wen   = (r_state == S_MEM) && r_is_store;
    o_pc_we     = (r_state == S_WB);
    o_rf_we     = (r_state == S_WB) && !r_is_branch && !r_is_store;
    o_pc_sel    = r_pc_cls;
    if (r_is_branch) o_pc_sel = ((r_state == S_WB) && i_br_taken) ? 2'd1 : 2'd0;
    o_inst_q    = r_inst;
    o_imm_sel   = r_imm_sel;
    o_alu_a_pc  = r_a_pc;
    o_alu_b_imm = r_b_imm;
    o_wb_sel    = r_wb_sel;
    o_halt      = (r_state == S_HALT);
    o_illegal   = r_illegal;
    o_bus_err   = r_bus_err;
  end

endmodule
